// File: rtl/apb_vec_acc.sv
// apb_vec_acc: APB-attached vector accelerator.
// Software loads operand buffers A and B, sets LEN and MODE, then writes START.
// The engine produces one OUT element per cycle and raises a sticky DONE flag.
// Optional feature macro: APB_VEC_ACC_IRQ_EN (adds irq_o and the CTRL.IE bit).
module apb_vec_acc #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR
`ifdef APB_VEC_ACC_IRQ_EN
  ,
  output logic                      irq_o
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_r;
  logic [8:0]            idx_r;
  logic [8:0]            len_r;
  logic [1:0]            mode_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] a_mem_r   [DEPTH];
  logic [DATA_WIDTH-1:0] b_mem_r   [DEPTH];
  logic [DATA_WIDTH-1:0] out_mem_r [DEPTH];

  logic [1:0]       region_s;
  logic [7:0]       word_s;
  logic [IDX_W-1:0] mem_idx_s;
  logic [IDX_W-1:0] eng_idx_s;
  logic             hi_zero_s;
  logic             in_range_s;
  logic             busy_s;
  logic             last_s;
  logic             eng_wr_s;
  logic             err_s;
  logic [31:0]      rdata_s;
  logic             wr_ok_s;
  logic             ctrl_wr_s;
  logic             status_wr_s;
  logic             len_wr_s;
  logic             a_wr_s;
  logic             b_wr_s;
  logic             start_s;
  logic             done_nxt_s;
  logic             ie_s;
  logic             unused_s;

  // Element-wise operation; all results wrap modulo 2^DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] vec_op(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    case (mode)
      2'd0:    vec_op = a + b;
      2'd1:    vec_op = a - b;
      2'd2:    vec_op = a * b;
      2'd3:    vec_op = a ^ b;
      default: vec_op = a ^ b;
    endcase
  endfunction

  // Address fields: [11:10] selects registers/A/B/OUT, [9:2] is the word index.
  assign region_s   = PADDR[11:10];
  assign word_s     = PADDR[9:2];
  assign mem_idx_s  = word_s[IDX_W-1:0];
  assign eng_idx_s  = idx_r[IDX_W-1:0];
  assign in_range_s = ({1'b0, word_s} < 9'(DEPTH));
  assign busy_s     = (state_r == ST_RUN);
  assign last_s     = busy_s && (idx_r == (len_r - 9'd1));
  assign eng_wr_s   = HRESETn && busy_s;
  assign unused_s   = ^{PWDATA, PADDR[1:0]};

  generate
    if (APB_ADDR_WIDTH > 12) begin : g_hi_addr
      assign hi_zero_s = ~|PADDR[APB_ADDR_WIDTH-1:12];
    end else begin : g_no_hi_addr
      assign hi_zero_s = 1'b1;
    end
  endgenerate

  // Read mux and error decode; errors depend only on address, direction, data and state.
  always_comb begin
    err_s   = 1'b0;
    rdata_s = 32'd0;
    if (!hi_zero_s) begin
      err_s = 1'b1;
    end else begin
      case (region_s)
        2'b00: begin
          case (word_s)
            8'd0: begin
              rdata_s = {28'd0, ie_s, mode_r, 1'b0};
              if (PWRITE && busy_s && (PWDATA[2:0] != 3'd0)) begin
                err_s = 1'b1;
              end else if (PWRITE && PWDATA[0] &&
                           ((len_r == 9'd0) || (len_r > 9'(DEPTH)))) begin
                err_s = 1'b1;
              end else begin
                err_s = 1'b0;
              end
            end
            8'd1: begin
              rdata_s = {30'd0, done_r, busy_s};
            end
            8'd2: begin
              rdata_s = {23'd0, len_r};
              if (PWRITE && busy_s) begin
                err_s = 1'b1;
              end else begin
                err_s = 1'b0;
              end
            end
            default: begin
              err_s = 1'b1;
            end
          endcase
        end
        2'b01: begin
          if (!in_range_s || (PWRITE && busy_s)) begin
            err_s = 1'b1;
          end else begin
            rdata_s = 32'(a_mem_r[mem_idx_s]);
          end
        end
        2'b10: begin
          if (!in_range_s || (PWRITE && busy_s)) begin
            err_s = 1'b1;
          end else begin
            rdata_s = 32'(b_mem_r[mem_idx_s]);
          end
        end
        2'b11: begin
          if (!in_range_s || PWRITE) begin
            err_s = 1'b1;
          end else begin
            rdata_s = 32'(out_mem_r[mem_idx_s]);
          end
        end
        default: begin
          err_s = 1'b1;
        end
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL && PENABLE && err_s;
  assign PRDATA  = (PSEL && !PWRITE) ? rdata_s : 32'd0;

  // Accepted write strobes; an erroring access never changes state.
  assign wr_ok_s     = HRESETn && PSEL && PENABLE && PWRITE && !err_s;
  assign ctrl_wr_s   = wr_ok_s && (region_s == 2'b00) && (word_s == 8'd0);
  assign status_wr_s = wr_ok_s && (region_s == 2'b00) && (word_s == 8'd1);
  assign len_wr_s    = wr_ok_s && (region_s == 2'b00) && (word_s == 8'd2);
  assign a_wr_s      = wr_ok_s && (region_s == 2'b01);
  assign b_wr_s      = wr_ok_s && (region_s == 2'b10);
  assign start_s     = ctrl_wr_s && PWDATA[0];

  // DONE next value: completion wins over a coincident write-1-clear.
  always_comb begin
    done_nxt_s = done_r;
    if (start_s) begin
      done_nxt_s = 1'b0;
    end else if (last_s) begin
      done_nxt_s = 1'b1;
    end else if (status_wr_s && PWDATA[1]) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end
  end

`ifdef APB_VEC_ACC_IRQ_EN
  logic ie_r;
  logic ie_nxt_s;
  logic irq_r;

  // IE next value: any accepted CTRL write carries the new enable.
  always_comb begin
    ie_nxt_s = ie_r;
    if (ctrl_wr_s) begin
      ie_nxt_s = PWDATA[3];
    end else begin
      ie_nxt_s = ie_r;
    end
  end

  // Interrupt enable and level interrupt, registered alongside DONE.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ie_r  <= 1'b0;
      irq_r <= 1'b0;
    end else begin
      ie_r  <= ie_nxt_s;
      irq_r <= done_nxt_s && ie_nxt_s;
    end
  end

  assign ie_s  = ie_r;
  assign irq_o = irq_r;
`else
  assign ie_s = 1'b0;
`endif

  // Control FSM: IDLE waits for a valid START, RUN walks idx up to LEN-1.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
      idx_r   <= 9'd0;
      len_r   <= 9'(DEPTH);
      mode_r  <= 2'd0;
      done_r  <= 1'b0;
    end else begin
      done_r <= done_nxt_s;
      if (len_wr_s) begin
        len_r <= PWDATA[8:0];
      end
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r <= ST_RUN;
            idx_r   <= 9'd0;
            mode_r  <= PWDATA[2:1];
          end else if (ctrl_wr_s) begin
            mode_r <= PWDATA[2:1];
          end
        end
        ST_RUN: begin
          idx_r <= idx_r + 9'd1;
          if (last_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Buffer storage: APB fills A and B, the engine fills OUT; contents survive reset.
  always_ff @(posedge HCLK) begin
    if (a_wr_s) begin
      a_mem_r[mem_idx_s] <= PWDATA[DATA_WIDTH-1:0];
    end
    if (b_wr_s) begin
      b_mem_r[mem_idx_s] <= PWDATA[DATA_WIDTH-1:0];
    end
    if (eng_wr_s) begin
      out_mem_r[eng_idx_s] <= vec_op(mode_r, a_mem_r[eng_idx_s], b_mem_r[eng_idx_s]);
    end
  end

endmodule

// File: tb/tb_apb_vec_acc.sv
// tb_apb_vec_acc: directed self-checking bench for apb_vec_acc (default parameters).
module tb_apb_vec_acc;

  localparam logic [11:0] A_CTRL   = 12'h000;
  localparam logic [11:0] A_STATUS = 12'h004;
  localparam logic [11:0] A_LEN    = 12'h008;
  localparam logic [11:0] A_ABUF   = 12'h400;
  localparam logic [11:0] A_BBUF   = 12'h800;
  localparam logic [11:0] A_OBUF   = 12'hC00;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
`ifdef APB_VEC_ACC_IRQ_EN
  logic        irq_o;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] rd_v;
  logic        err_v;
  logic        got_done;

  logic [7:0] a_init [8] = '{8'h01, 8'h02, 8'hFF, 8'h80, 8'd10, 8'd20, 8'd30, 8'd40};
  logic [7:0] b_init [8] = '{8'h01, 8'h03, 8'h01, 8'h80, 8'd1,  8'd2,  8'd3,  8'd4};
  logic [7:0] exp_tab [4][4] = '{
    '{8'h02, 8'h05, 8'h00, 8'h00},
    '{8'h00, 8'hFF, 8'hFE, 8'h00},
    '{8'h01, 8'h06, 8'hFF, 8'h00},
    '{8'h00, 8'h01, 8'hFE, 8'h00}
  };

  apb_vec_acc dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
`ifdef APB_VEC_ACC_IRQ_EN
    ,
    .irq_o   (irq_o)
`endif
  );

  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end 1ns after a rising edge.
  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #4;
    err = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #4;
    data = PRDATA;
    err  = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr_ok(input string tag, input logic [11:0] addr, input logic [31:0] data);
    logic e;
    apb_write(addr, data, e);
    check_val({tag, "_err"}, 32'(e), 32'd0);
  endtask

  task automatic wr_bad(input string tag, input logic [11:0] addr, input logic [31:0] data);
    logic e;
    apb_write(addr, data, e);
    check_val({tag, "_err"}, 32'(e), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(addr, d, e);
    check_val(tag, d, exp);
    check_val({tag, "_err"}, 32'(e), 32'd0);
  endtask

  // Start the engine, then hold a STATUS read open and check BUSY/DONE every cycle.
  task automatic run_watch(input string tag, input logic [1:0] mode, input int len);
    wr_ok({tag, "_start"}, A_CTRL, {28'd0, 1'b0, mode, 1'b1});
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = A_STATUS;
    for (int k = 0; k <= len; k++) begin
      #4;
      check_val($sformatf("%s_busy%0d", tag, k), 32'(PRDATA[0]), (k < len) ? 32'd1 : 32'd0);
      check_val($sformatf("%s_done%0d", tag, k), 32'(PRDATA[1]), (k == len) ? 32'd1 : 32'd0);
      @(posedge HCLK); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 12'h000; PWDATA = 32'd0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Reset state
    check_val("rst_pready", 32'(PREADY), 32'd1);
    check_val("rst_pslverr", 32'(PSLVERR), 32'd0);
    check_val("rst_prdata", PRDATA, 32'd0);
`ifdef APB_VEC_ACC_IRQ_EN
    check_val("rst_irq", 32'(irq_o), 32'd0);
`endif
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_status", A_STATUS, 32'h0);
    rd_chk("rst_len", A_LEN, 32'h100);

    // Load operands
    for (int i = 0; i < 8; i++) begin
      wr_ok("ld_a", A_ABUF + 12'(i * 4), {24'd0, a_init[i]});
      wr_ok("ld_b", A_BBUF + 12'(i * 4), {24'd0, b_init[i]});
    end
    rd_chk("rb_a2", A_ABUF + 12'h008, 32'h0000_00FF);
    wr_ok("len4", A_LEN, 32'd4);

    // Each mode on the same operands
    for (int m = 0; m < 4; m++) begin
      run_watch($sformatf("m%0d", m), 2'(m), 4);
      for (int i = 0; i < 4; i++) begin
        rd_chk($sformatf("m%0d_out%0d", m, i), A_OBUF + 12'(i * 4), {24'd0, exp_tab[m][i]});
      end
    end

    // Error cases (state: idle, DONE=1, OUT = xor results)
    wr_ok("len0", A_LEN, 32'd0);
    wr_bad("start_len0", A_CTRL, 32'h1);
    rd_chk("st_len0", A_STATUS, 32'h2);
    wr_ok("len257", A_LEN, 32'd257);
    wr_bad("start_len257", A_CTRL, 32'h1);
    rd_chk("st_len257", A_STATUS, 32'h2);
    wr_bad("wr_out0", A_OBUF, 32'h55);
    rd_chk("out0_kept", A_OBUF, 32'h0);
    apb_read(12'h010, rd_v, err_v);
    check_val("rd_unmapped_err", 32'(err_v), 32'd1);
    rd_chk("st_unmapped", A_STATUS, 32'h2);

    // Errors while running: LEN=8 add, start at edge T
    wr_ok("len8", A_LEN, 32'd8);
    wr_ok("run8_start", A_CTRL, 32'h1);
    wr_bad("run8_wr_a0", A_ABUF, 32'h77);
    wr_bad("run8_start2", A_CTRL, 32'h1);
    rd_chk("run8_status", A_STATUS, 32'h1);
    got_done = 1'b0;
    for (int n = 0; n < 20 && !got_done; n++) begin
      apb_read(A_STATUS, rd_v, err_v);
      if (rd_v[1]) got_done = 1'b1;
    end
    check_val("run8_done", 32'(got_done), 32'd1);
    rd_chk("run8_a0", A_ABUF, 32'h1);
    rd_chk("run8_out0", A_OBUF, 32'h2);
    rd_chk("run8_out7", A_OBUF + 12'h01C, 32'd44);
    rd_chk("run8_ctrl", A_CTRL, 32'h0);

    // DONE W1C landing exactly on the completion edge, IE=1
    wr_ok("len4b", A_LEN, 32'd4);
    wr_ok("w1c_start", A_CTRL, 32'h9);
    repeat (2) @(posedge HCLK);
    #1;
    wr_ok("w1c_edge", A_STATUS, 32'h2);
    rd_chk("w1c_st_set", A_STATUS, 32'h2);
`ifdef APB_VEC_ACC_IRQ_EN
    check_val("irq_set", 32'(irq_o), 32'd1);
    rd_chk("ctrl_ie", A_CTRL, 32'h8);
`else
    rd_chk("ctrl_ie_raz", A_CTRL, 32'h0);
`endif
    wr_ok("w1c_late", A_STATUS, 32'h2);
    rd_chk("w1c_st_clr", A_STATUS, 32'h0);
`ifdef APB_VEC_ACC_IRQ_EN
    check_val("irq_clr", 32'(irq_o), 32'd0);
`endif

    // Reset at RUN index 2 of LEN=8, xor mode
    wr_ok("len8b", A_LEN, 32'd8);
    wr_ok("rst_start", A_CTRL, 32'h7);
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    rd_chk("rr_status", A_STATUS, 32'h0);
    rd_chk("rr_len", A_LEN, 32'h100);
    rd_chk("rr_out0", A_OBUF, 32'h0);
    rd_chk("rr_out1", A_OBUF + 12'h004, 32'h1);

    // Fresh run after reset
    wr_ok("len4c", A_LEN, 32'd4);
    run_watch("post", 2'd0, 4);
    for (int i = 0; i < 4; i++) begin
      rd_chk($sformatf("post_out%0d", i), A_OBUF + 12'(i * 4), {24'd0, exp_tab[0][i]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
